fll_cfg_slave: RTL and testbench

FLL_CFG_SLAVE -- requirements
Module: fll_cfg_slave

---
 rtl/fll_cfg_slave_if.sv | 20 ++
 rtl/fll_cfg_slave.sv | 124 ++++++++++++
 tb/tb_fll_cfg_slave.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fll_cfg_slave_if.sv
// Four-phase request/acknowledge register-access bus between the FLL
// configuration master and fll_cfg_slave.
interface fll_cfg_slave_if;
  logic        fll_req;
  logic        fll_wrn;
  logic [1:0]  fll_add;
  logic [31:0] fll_data;
  logic        fll_ack;
  logic [31:0] fll_r_data;

  modport master (
    output fll_req, fll_wrn, fll_add, fll_data,
    input  fll_ack, fll_r_data
  );

  modport slave (
    input  fll_req, fll_wrn, fll_add, fll_data,
    output fll_ack, fll_r_data
  );
endinterface

// File: rtl/fll_cfg_slave.sv
// FLL configuration register slave: STATUS/CFG1..3 over a four-phase handshake,
// with settle counter and lock flag. Define FLL_REQ_SYNC_EN to synchronize fll_req.
module fll_cfg_slave #(
  parameter int unsigned LOCK_SETTLE = 64
) (
  input  logic          HCLK,
  input  logic          HRESET,
  fll_cfg_slave_if.slave bus,
  output logic          fll_lock,
  output logic [31:0]   cfg1_o,
  output logic [31:0]   cfg2_o,
  output logic [31:0]   cfg3_o
);

  typedef enum logic {IDLE, ACK} state_t;

  localparam logic [15:0] SETTLE    = 16'(LOCK_SETTLE);
  localparam logic [31:0] CFG1_RST  = 32'h0000_0100;

  state_t      state_q, state_d;
  logic        req_s;
  logic [31:0] cfg1_q, cfg1_d;
  logic [31:0] cfg2_q, cfg2_d;
  logic [31:0] cfg3_q, cfg3_d;
  logic [31:0] rdata_q, rdata_d;
  logic [15:0] cnt_q, cnt_d;
  logic        lock_q, lock_d;
  logic        cfg1_wr;
  logic [31:0] status;

`ifdef FLL_REQ_SYNC_EN
  logic sync1_q, sync2_q;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= bus.fll_req;
      sync2_q <= sync1_q;
    end
  end

  assign req_s = sync2_q;
`else
  assign req_s = bus.fll_req;
`endif

  always_comb begin
    state_d = state_q;
    cfg1_d  = cfg1_q;
    cfg2_d  = cfg2_q;
    cfg3_d  = cfg3_q;
    rdata_d = rdata_q;
    cfg1_wr = 1'b0;
    status  = {lock_q, 15'd0, cnt_q};

    case (state_q)
      IDLE: begin
        // The single access of each request phase happens on this transition.
        if (req_s) begin
          state_d = ACK;
          if (bus.fll_wrn) begin
            case (bus.fll_add)
              2'd0:    rdata_d = status;
              2'd1:    rdata_d = cfg1_q;
              2'd2:    rdata_d = cfg2_q;
              default: rdata_d = cfg3_q;
            endcase
          end else begin
            case (bus.fll_add)
              2'd1: begin
                cfg1_d  = bus.fll_data;
                cfg1_wr = 1'b1;
              end
              2'd2:    cfg2_d = bus.fll_data;
              2'd3:    cfg3_d = bus.fll_data;
              default: ;
            endcase
          end
        end
      end
      ACK: begin
        if (!req_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (cfg1_wr)            cnt_d = SETTLE;
    else if (cnt_q != 16'd0) cnt_d = cnt_q - 16'd1;
    else                    cnt_d = cnt_q;

    // A CFG1 write wins over the counter expiring; open-loop mode never locks.
    lock_d = !cfg1_wr && (cnt_q == 16'd0) && !cfg1_q[30];
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q <= IDLE;
      cfg1_q  <= CFG1_RST;
      cfg2_q  <= 32'd0;
      cfg3_q  <= 32'd0;
      rdata_q <= 32'd0;
      cnt_q   <= SETTLE;
      lock_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cfg1_q  <= cfg1_d;
      cfg2_q  <= cfg2_d;
      cfg3_q  <= cfg3_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      lock_q  <= lock_d;
    end
  end

  assign bus.fll_ack    = (state_q == ACK);
  assign bus.fll_r_data = rdata_q;
  assign fll_lock       = lock_q;
  assign cfg1_o         = cfg1_q;
  assign cfg2_o         = cfg2_q;
  assign cfg3_o         = cfg3_q;

endmodule

// File: tb/tb_fll_cfg_slave.sv
// Self-checking bench for fll_cfg_slave: directed table, corner sequences and
// randomized accesses against a time-based register/lock model.
module tb_fll_cfg_slave;

  localparam int LS = 64;
`ifdef FLL_REQ_SYNC_EN
  localparam int L = 3;
`else
  localparam int L = 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        fll_lock;
  logic [31:0] cfg1_o, cfg2_o, cfg3_o;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  fll_cfg_slave_if bus ();

  fll_cfg_slave #(.LOCK_SETTLE(LS)) dut (
    .HCLK     (clk),
    .HRESET   (rst),
    .bus      (bus),
    .fll_lock (fll_lock),
    .cfg1_o   (cfg1_o),
    .cfg2_o   (cfg2_o),
    .cfg3_o   (cfg3_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Model: settle count is a pure function of edges since the last reload.
  logic [31:0] m_cfg1, m_cfg2, m_cfg3, m_rd;
  int          ref_edge;

  function automatic logic [15:0] m_cnt(input int k);
    int d;
    d = k - ref_edge;
    if (d >= LS) return 16'd0;
    return 16'(LS - d);
  endfunction

  function automatic logic m_lock(input int k);
    return ((k - ref_edge) >= LS + 1) && !m_cfg1[30];
  endfunction

  task automatic m_reset();
    m_cfg1   = 32'h0000_0100;
    m_cfg2   = 32'd0;
    m_cfg3   = 32'd0;
    m_rd     = 32'd0;
    ref_edge = cyc;
  endtask

  task automatic m_access(input logic wrn, input logic [1:0] add,
                          input logic [31:0] data, input int a);
    if (wrn) begin
      case (add)
        2'd0:    m_rd = {m_lock(a - 1), 15'd0, m_cnt(a - 1)};
        2'd1:    m_rd = m_cfg1;
        2'd2:    m_rd = m_cfg2;
        default: m_rd = m_cfg3;
      endcase
    end else begin
      case (add)
        2'd1: begin m_cfg1 = data; ref_edge = a; end
        2'd2: m_cfg2 = data;
        2'd3: m_cfg3 = data;
        default: ;
      endcase
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_state(input string tag);
    chk({tag, "_rdata"}, bus.fll_r_data, m_rd);
    chk({tag, "_cfg1"}, cfg1_o, m_cfg1);
    chk({tag, "_cfg2"}, cfg2_o, m_cfg2);
    chk({tag, "_cfg3"}, cfg3_o, m_cfg3);
    chk({tag, "_lock"}, {31'd0, fll_lock}, {31'd0, m_lock(cyc)});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      chk("idle_lock", {31'd0, fll_lock}, {31'd0, m_lock(cyc)});
    end
  endtask

  // Waits (bounded) for fll_ack to reach level; lock checked on every cycle before it.
  task automatic wait_ack(input logic level, output int a, output bit got);
    got = 1'b0;
    a   = cyc;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.fll_ack === level) begin
        got = 1'b1;
        a   = cyc;
        break;
      end
      chk("wait_lock", {31'd0, fll_lock}, {31'd0, m_lock(cyc)});
    end
    if (!got) chk("ack_timeout", {31'd0, bus.fll_ack}, {31'd0, level});
  endtask

  task automatic do_access(input logic wrn, input logic [1:0] add, input logic [31:0] data);
    int n, a;
    bit got;
    @(negedge clk);
    bus.fll_wrn  = wrn;
    bus.fll_add  = add;
    bus.fll_data = data;
    bus.fll_req  = 1'b1;
    n = cyc;
    wait_ack(1'b1, a, got);
    if (got) begin
      chk("ack_rise_lat", 32'(a - n), 32'(L));
      m_access(wrn, add, data, a);
      chk_state(wrn ? "rd" : "wr");
    end
    bus.fll_req = 1'b0;
    n = cyc;
    wait_ack(1'b0, a, got);
    if (got) chk("ack_fall_lat", 32'(a - n), 32'(L));
  endtask

  typedef struct {
    logic        wrn;
    logic [1:0]  add;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t vt[9];

  initial begin
    int n, a, pulses, first_a;
    bit got;
    logic prev, wrn;
    logic [1:0] add;
    logic [31:0] data;

    vt[0] = '{1'b0, 2'd2, 32'hCAFE_0123, 32'h0};
    vt[1] = '{1'b1, 2'd2, 32'h0,         32'hCAFE_0123};
    vt[2] = '{1'b0, 2'd3, 32'hA5A5_5A5A, 32'h0};
    vt[3] = '{1'b1, 2'd3, 32'h0,         32'hA5A5_5A5A};
    vt[4] = '{1'b0, 2'd0, 32'hFFFF_FFFF, 32'h0};
    vt[5] = '{1'b1, 2'd1, 32'h0,         32'h0000_0100};
    vt[6] = '{1'b1, 2'd0, 32'h0,         32'h8000_0000};
    vt[7] = '{1'b0, 2'd1, 32'h0000_0200, 32'h0};
    vt[8] = '{1'b1, 2'd1, 32'h0,         32'h0000_0200};

    rst = 1'b1;
    bus.fll_req  = 1'b0;
    bus.fll_wrn  = 1'b0;
    bus.fll_add  = 2'd0;
    bus.fll_data = 32'd0;
    m_reset();
    repeat (3) @(negedge clk);
    chk("rst_ack", {31'd0, bus.fll_ack}, 32'd0);
    chk_state("rst");
    rst = 1'b0;
    m_reset();

    // Status immediately after reset, then once settled.
    do_access(1'b1, 2'd0, 32'd0);
    chk("status_counting", {16'd0, bus.fll_r_data[31:16]}, 32'd0);
    idle(LS);
    do_access(1'b1, 2'd0, 32'd0);
    chk("status_locked", bus.fll_r_data, 32'h8000_0000);

    for (int i = 0; i < 9; i++) begin
      if (i == 7) chk("lock_before_cfg1_wr", {31'd0, fll_lock}, 32'd1);
      do_access(vt[i].wrn, vt[i].add, vt[i].data);
      if (vt[i].wrn) chk($sformatf("vec%0d_rdata", i), bus.fll_r_data, vt[i].exp);
    end
    chk("vec_cfg2_out", cfg2_o, 32'hCAFE_0123);
    idle(LS + 2);
    chk("relock", {31'd0, fll_lock}, 32'd1);

    // Open loop: never locks, counter runs out to zero.
    do_access(1'b0, 2'd1, 32'h4000_0000);
    idle(200);
    chk("openloop_lock", {31'd0, fll_lock}, 32'd0);
    do_access(1'b1, 2'd0, 32'd0);
    chk("openloop_status", bus.fll_r_data, 32'h0000_0000);
    do_access(1'b0, 2'd1, 32'h0000_0100);

    // Held request with inputs changing mid-access: one ack, first data kept.
    @(negedge clk);
    bus.fll_wrn  = 1'b0;
    bus.fll_add  = 2'd3;
    bus.fll_data = 32'h1357_9BDF;
    bus.fll_req  = 1'b1;
    n = cyc;
    pulses = 0;
    first_a = -1;
    prev = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.fll_ack && !prev) begin
        pulses++;
        if (first_a < 0) begin
          first_a = cyc;
          m_access(1'b0, 2'd3, 32'h1357_9BDF, cyc);
        end
      end
      prev = bus.fll_ack;
      chk("held_lock", {31'd0, fll_lock}, {31'd0, m_lock(cyc)});
      if (i == 10) begin
        bus.fll_data = 32'h1;
        bus.fll_add  = 2'd2;
      end
    end
    bus.fll_req = 1'b0;
    idle(L + 3);
    chk("held_pulses", 32'(pulses), 32'd1);
    chk("held_lat", 32'(first_a - n), 32'(L));
    chk("held_ack_low", {31'd0, bus.fll_ack}, 32'd0);
    chk_state("held");

    // Reset during ACK with the request still high.
    @(negedge clk);
    bus.fll_wrn  = 1'b0;
    bus.fll_add  = 2'd2;
    bus.fll_data = 32'h1234_5678;
    bus.fll_req  = 1'b1;
    wait_ack(1'b1, a, got);
    if (got) m_access(1'b0, 2'd2, 32'h1234_5678, a);
    @(negedge clk);
    rst = 1'b1;
    #1;
    m_reset();
    chk("midrst_ack", {31'd0, bus.fll_ack}, 32'd0);
    chk_state("midrst");
    @(negedge clk);
    rst = 1'b0;
    m_reset();
    n = cyc;
    wait_ack(1'b1, a, got);
    if (got) begin
      chk("midrst_relat", 32'(a - n), 32'(L));
      m_access(1'b0, 2'd2, 32'h1234_5678, a);
      chk_state("midrst_re");
    end
    bus.fll_req = 1'b0;
    wait_ack(1'b0, a, got);

    // Randomized accesses with random idle gaps.
    for (int i = 0; i < 150; i++) begin
      wrn  = 1'($urandom_range(0, 1));
      add  = 2'($urandom_range(0, 3));
      data = $urandom;
      if (add == 2'd1) data[30] = ($urandom_range(0, 3) == 0);
      do_access(wrn, add, data);
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(0, 80)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
